angle_reducer: RTL and testbench
================================

// Module: angle_reducer
// PURPOSE
//  Upstream stage of sine_calculator. Accepts a signed Q16.16 angle in radians and range-reduces it.
//  It folds the angle by quadrant into [0, pi/2], scales it to a non-negative LUT address, and
//  emits a sign flag for the downstream negation. Multi-cycle shift-subtract modulo-2pi.
//  Uses a valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH       32   angle/address width, signed two's complement
//  FRAC_BITS   16   fractional bits of the angle (Q16.16)
//  ADDR_SCALE  300  address = floor(reduced_angle_rad * ADDR_SCALE); must match LUT indexing
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  in_valid_i   in   1      angle_i valid
//  in_ready_o   out  1      block can accept (high only in IDLE)
//  angle_i      in   WIDTH  signed Q16.16 angle, radians
//  out_valid_o  out  1      addr_o/neg_o valid
//  out_ready_i  in   1      consumer accepts result
//  addr_o       out  WIDTH  signed LUT address, always >= 0
//  neg_o        out  1      1: downstream must negate the LUT output
// BEHAVIOUR
//  Reset: state=IDLE, in_ready_o=1, out_valid_o=0, addr_o=0, neg_o=0, working regs=0.
//  rst mid-operation: abort immediately, drop the in-flight angle, return to the reset values above.
//  Constants: TWO_PI_Q=411775, PI_Q=205887, HALF_PI_Q=102944 (round(x*2^16)).
//  FSM: IDLE -> REDUCE(13 cycles) -> FOLD -> SCALE -> DONE -> IDLE.
//  IDLE: on in_valid_i & in_ready_o, latch the following values:
//   neg = angle_i[31]; mag = |angle_i| in a 33-bit unsigned register; k = 12.
//   angle_i = 0x80000000 saturates to mag = 0x7FFFFFFF.
//  REDUCE: per cycle, if mag >= (TWO_PI_Q << k) then mag -= TWO_PI_Q << k. Decrement k.
//   Leave after the k=0 step; mag is then in [0, TWO_PI_Q).
//  FOLD (1 cycle), applied in this order:
//   1. If mag >= PI_Q: mag -= PI_Q and neg ^= 1.
//   2. Then if mag > HALF_PI_Q: mag = PI_Q - mag.
//   Result is mag in [0, HALF_PI_Q].
//  SCALE (1 cycle): addr = (mag * ADDR_SCALE) >> FRAC_BITS, using a 48-bit product, truncated (floor).
//  DONE: out_valid_o=1. addr_o and neg_o are registered and held stable while out_ready_i=0.
//   On out_ready_i=1, go to IDLE. No same-cycle re-accept.
//  Latency: out_valid_o rises exactly 15 clocks after the accepting edge.
//   Throughput is 1 result per >= 16 cycles.
//  in_ready_o=0 in every state except IDLE; in_valid_i is ignored there.
//  After DONE, addr_o/neg_o keep their last values (out_valid_o=0) until the next SCALE.
//  Zero angle: addr_o=0, neg_o=0 (a -0 input cannot occur in two's complement).
//  No X on outputs for any angle_i, including 0x7FFFFFFF and 0x80000000.
// STRUCTURE
//  Package sine_pkg holds the following:
//   - TWO_PI_Q, PI_Q, HALF_PI_Q localparams.
//   - typedef enum logic [2:0] {IDLE, REDUCE, FOLD, SCALE, DONE} reducer_state_t.
//   - typedef logic signed [31:0] q16_16_t.
//  sine_calculator imports sine_pkg for q16_16_t.
//  One sub-module: angle_fold. It is combinational and implements the FOLD rules.
//   Inputs: mag[32:0], neg. Outputs: mag_f, neg_f.
//   It is instantiated once and registered by the FSM.
// TESTING
//  Bench drives clk period 10, holds rst 2 cycles, and checks out_valid_o timing against the 15-clock latency.
//  Directed scenarios (angle_i -> addr_o, neg_o):
//   - 0x00000000 (0.0) -> 0, 0; out_valid_o 15 clocks after accept.
//   - 0x00010000 (1.0) -> 300, 0; 0xFFFF0000 (-1.0) -> 300, 1.
//   - 0x00020000 (2.0) -> 342, 0 (fold beyond pi/2); 0x00040000 (4.0) -> 257, 1 (>= pi).
//   - 0x00070000 (7.0) -> 215, 0 (one 2pi wrap); 0x80000000 -> completes in 15, addr_o <= 471, no X.
//   - Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> outputs stable, in_ready_o=0;
//     release -> IDLE next cycle.
//   - Assert rst at REDUCE cycle 6 -> next cycle in_ready_o=1, out_valid_o=0, addr_o=0;
//     the following request (1.0) returns 300.
//  Sweep -5.0..5.0 step 0.1 chained into sine_calculator.
//   Check: (neg_o ? -lut : lut) equals sin(x) within 0.01.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared constants and types for the sine pipeline (angle_reducer, sine_calculator).
package sine_pkg;

    // Q16.16 radian constants, round(x * 2^16)
    localparam int unsigned TWO_PI_Q  = 411775;
    localparam int unsigned PI_Q      = 205887;
    localparam int unsigned HALF_PI_Q = 102944;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        FOLD,
        SCALE,
        DONE
    } reducer_state_t;

    typedef logic signed [31:0] q16_16_t;

endpackage : sine_pkg

// File: rtl/angle_fold.sv
// Combinational quadrant fold: maps a magnitude in [0, 2pi) into [0, pi/2],
// toggling the sign flag when the angle lies in [pi, 2pi).
// Ports:
//   mag_i    in  MAG_W  unsigned Q16.16 magnitude, expected in [0, TWO_PI_Q)
//   neg_i    in  1      incoming sign flag
//   mag_f_o  out MAG_W  folded magnitude in [0, HALF_PI_Q]
//   neg_f_o  out 1      sign flag after the pi fold
module angle_fold
    import sine_pkg::*;
#(
    parameter int unsigned MAG_W = 33
) (
    input  logic [MAG_W-1:0] mag_i,
    input  logic             neg_i,
    output logic [MAG_W-1:0] mag_f_o,
    output logic             neg_f_o
);

    logic             ge_pi;
    logic [MAG_W-1:0] mag_half;

    // sin(x - pi) = -sin(x), then sin(pi - x) = sin(x)
    always_comb begin
        ge_pi    = (mag_i >= MAG_W'(PI_Q));
        mag_half = ge_pi ? (mag_i - MAG_W'(PI_Q)) : mag_i;
        neg_f_o  = neg_i ^ ge_pi;
        mag_f_o  = (mag_half > MAG_W'(HALF_PI_Q)) ? (MAG_W'(PI_Q) - mag_half) : mag_half;
    end

endmodule : angle_fold

// File: rtl/angle_reducer.sv
// Range reduction for the sine LUT: |angle| mod 2pi by 13-step shift-subtract,
// quadrant fold into [0, pi/2], then scaling to a LUT address. Result is
// available 15 clocks after the accepting edge and held until consumed.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid_i   angle_i valid
//   in_ready_o   high only while idle
//   angle_i      signed Q16.16 angle in radians
//   out_valid_o  addr_o/neg_o valid
//   out_ready_i  consumer accepts result
//   addr_o       LUT address, always >= 0
//   neg_o        downstream must negate the LUT output
module angle_reducer
    import sine_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FRAC_BITS  = 16,
    parameter int unsigned ADDR_SCALE = 300
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] angle_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] addr_o,
    output logic             neg_o
);

    localparam int unsigned MAG_W  = WIDTH + 1;
    localparam int unsigned K_W    = 4;
    localparam int unsigned PROD_W = 48;
    localparam logic [K_W-1:0] K_START = K_W'(12);

    reducer_state_t   state_q;
    logic [MAG_W-1:0] mag_q;
    logic             neg_q;
    logic [K_W-1:0]   k_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] addr_q;
    logic             neg_out_q;

    logic [WIDTH-1:0]  neg_angle_d;
    logic [MAG_W-1:0]  mag_abs_d;
    logic [MAG_W-1:0]  sub_d;
    logic [MAG_W-1:0]  mag_red_d;
    logic [MAG_W-1:0]  mag_f;
    logic              neg_f;
    logic [PROD_W-1:0] prod_d;
    logic [WIDTH-1:0]  addr_d;

    // Datapath: absolute value with saturation, one reduction step, address scaling
    always_comb begin
        neg_angle_d = -angle_i;
        mag_abs_d   = {1'b0, angle_i};
        if (angle_i[WIDTH-1]) begin
            // most-negative input has no positive counterpart; clamp to max positive
            if (angle_i == {1'b1, {(WIDTH-1){1'b0}}}) begin
                mag_abs_d = {2'b00, {(WIDTH-1){1'b1}}};
            end else begin
                mag_abs_d = {1'b0, neg_angle_d};
            end
        end
        sub_d     = MAG_W'(TWO_PI_Q) << k_q;
        mag_red_d = (mag_q >= sub_d) ? (mag_q - sub_d) : mag_q;
        prod_d    = PROD_W'(mag_q) * PROD_W'(ADDR_SCALE);
        addr_d    = WIDTH'(prod_d >> FRAC_BITS);
    end

    angle_fold #(
        .MAG_W (MAG_W)
    ) u_fold (
        .mag_i   (mag_q),
        .neg_i   (neg_q),
        .mag_f_o (mag_f),
        .neg_f_o (neg_f)
    );

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            addr_q      <= '0;
            neg_out_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        mag_q      <= mag_abs_d;
                        neg_q      <= angle_i[WIDTH-1];
                        k_q        <= K_START;
                        in_ready_q <= 1'b0;
                        state_q    <= REDUCE;
                    end
                end
                REDUCE: begin
                    mag_q <= mag_red_d;
                    if (k_q == '0) begin
                        state_q <= FOLD;
                    end else begin
                        k_q <= k_q - K_W'(1);
                    end
                end
                FOLD: begin
                    mag_q   <= mag_f;
                    neg_q   <= neg_f;
                    state_q <= SCALE;
                end
                SCALE: begin
                    addr_q      <= addr_d;
                    neg_out_q   <= neg_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign addr_o      = addr_q;
    assign neg_o       = neg_out_q;

endmodule : angle_reducer

// File: tb/tb_angle_reducer.sv
// Directed bench for angle_reducer: reset values, latency, reduction/fold results,
// saturation extremes, output backpressure and mid-operation reset.
module tb_angle_reducer;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] angle_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] addr_o;
    logic        neg_o;

    int checks = 0;
    int errors = 0;

    angle_reducer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .angle_i     (angle_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .addr_o      (addr_o),
        .neg_o       (neg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request and waits for out_valid_o; returns observations only.
    // lat = clocks from accepting edge to out_valid_o, or -1 on timeout.
    task automatic issue(input logic [31:0] ang, output int lat,
                         output logic [31:0] a, output logic n, output logic ir);
        lat = -1;
        @(negedge clk);
        angle_i    = ang;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        angle_i    = 32'hDEAD_BEEF;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_o === 1'b1) begin
                lat = i;
                break;
            end
        end
        a  = addr_o;
        n  = neg_o;
        ir = in_ready_o;
    endtask

    task automatic test_reset();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid_o); end
        checks++; if (addr_o !== 32'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", addr_o); end
        checks++; if (neg_o !== 1'b0) begin errors++; $display("FAIL reset_neg got %b exp 0", neg_o); end
    endtask

    task automatic test_vectors();
        logic [31:0] vin  [8] = '{32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0002_0000,
                                  32'h0003_0000, 32'h0004_0000, 32'h0007_0000, 32'hFFF9_0000};
        logic [31:0] vadr [8] = '{32'd0, 32'd300, 32'd300, 32'd342, 32'd42, 32'd257, 32'd215, 32'd215};
        logic        vneg [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat; logic [31:0] a; logic n; logic ir;
        for (int v = 0; v < 8; v++) begin
            issue(vin[v], lat, a, n, ir);
            checks++; if (lat != 15) begin errors++; $display("FAIL vec%0d_latency got %0d exp 15", v, lat); end
            checks++; if (a !== vadr[v]) begin errors++; $display("FAIL vec%0d_addr got %0d exp %0d", v, a, vadr[v]); end
            checks++; if (n !== vneg[v]) begin errors++; $display("FAIL vec%0d_neg got %b exp %b", v, n, vneg[v]); end
            checks++; if (ir !== 1'b0) begin errors++; $display("FAIL vec%0d_ready_in_done got %b exp 0", v, ir); end
            // out_ready_i is high, so the next edge returns to IDLE and holds the result
            @(posedge clk); #1;
            checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
                errors++; $display("FAIL vec%0d_release valid %b ready %b exp 0 1", v, out_valid_o, in_ready_o);
            end
            checks++; if (addr_o !== vadr[v] || neg_o !== vneg[v]) begin
                errors++; $display("FAIL vec%0d_hold addr %0d neg %b exp %0d %b", v, addr_o, neg_o, vadr[v], vneg[v]);
            end
        end
    endtask

    task automatic test_extremes();
        logic [31:0] vin  [2] = '{32'h8000_0000, 32'h7FFF_FFFF};
        logic        vneg [2] = '{1'b1, 1'b0};
        int lat; logic [31:0] a; logic n; logic ir;
        // 0x7FFFFFFF mod 411775 = 77022 -> floor(77022*300/65536) = 352
        for (int v = 0; v < 2; v++) begin
            issue(vin[v], lat, a, n, ir);
            checks++; if (lat != 15) begin errors++; $display("FAIL ext%0d_latency got %0d exp 15", v, lat); end
            checks++; if ($isunknown({a, n}) || a !== 32'd352) begin errors++; $display("FAIL ext%0d_addr got %0d exp 352", v, a); end
            checks++; if (n !== vneg[v]) begin errors++; $display("FAIL ext%0d_neg got %b exp %b", v, n, vneg[v]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] a; logic n; logic ir;
        out_ready_i = 1'b0;
        issue(32'h0002_0000, lat, a, n, ir);
        checks++; if (lat != 15 || a !== 32'd342) begin errors++; $display("FAIL bp_first lat %0d addr %0d exp 15 342", lat, a); end
        // offer a new request while busy; it must be ignored
        @(negedge clk);
        angle_i    = 32'h0001_0000;
        in_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid_o !== 1'b1 || addr_o !== 32'd342 || neg_o !== 1'b0 || in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d valid %b addr %0d neg %b ready %b exp 1 342 0 0",
                         c, out_valid_o, addr_o, neg_o, in_ready_o);
            end
        end
        @(negedge clk);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL bp_release ready %b valid %b exp 1 0", in_ready_o, out_valid_o);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++; $display("FAIL bp_ignored_req valid %b ready %b exp 0 1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] a; logic n; logic ir;
        // addr_o currently holds 342 from the previous scenario
        @(negedge clk);
        angle_i    = 32'h0004_0000;
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++; $display("FAIL midrst_handshake ready %b valid %b exp 1 0", in_ready_o, out_valid_o);
        end
        checks++; if (addr_o !== 32'd0 || neg_o !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs addr %0d neg %b exp 0 0", addr_o, neg_o);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(32'h0001_0000, lat, a, n, ir);
        checks++; if (lat != 15 || a !== 32'd300 || n !== 1'b0) begin
            errors++; $display("FAIL midrst_next lat %0d addr %0d neg %b exp 15 300 0", lat, a, n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        angle_i     = '0;
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_vectors();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_angle_reducer
